dm_arbiter: RTL and testbench

Arbiter and sequencer for the shared 4 KiB data memory (1024 × 32-bit words). It sits between the pipeline MEM stage (port C) and an external loader/DMA port (port E), and drives the memory's single write/read port. The CPU has fixed priority, and an aging counter guarantees the external port a slot within bounded time. External reads return through a registered response path.

---
 rtl/dm_arb_pkg.sv | 17 +
 rtl/dm_arbiter_if.sv | 48 ++++
 rtl/dm_arb_age.sv | 23 ++
 rtl/dm_arbiter.sv | 79 +++++++
 tb/tb_dm_arbiter.sv | 244 ++++++++++++++++++++++++
 5 files changed

// File: rtl/dm_arb_pkg.sv
// dm_arb_pkg: shared port-select type, byte-enable constants and address width for dm_arbiter.
package dm_arb_pkg;

    typedef enum logic [1:0] {PORT_NONE, PORT_C, PORT_E} portSel_t;

    localparam logic [3:0] BE_WORD   = 4'b1111;
    localparam logic [3:0] BE_NONE   = 4'b0000;
    localparam int         DM_ADDR_W = 10;

    // Expand per-lane byte enables into a 32-bit bit mask.
    function automatic logic [31:0] beMask(input logic [3:0] be);
        logic [31:0] m;
        for (int k = 0; k < 4; k++) m[8*k +: 8] = {8{be[k]}};
        return m;
    endfunction

endpackage

// File: rtl/dm_arbiter_if.sv
// dm_arbiter_if: CPU port, external port and memory-side bundle of the data-memory arbiter.
interface dm_arbiter_if
    import dm_arb_pkg::*;
#(
    parameter int ADDR_W = DM_ADDR_W
);
    logic              c_req;
    logic              c_we;
    logic [3:0]        c_be;
    logic [ADDR_W-1:0] c_addr;
    logic [31:0]       c_wdata;
    logic [31:0]       c_rdata;
    logic              c_stall;

    logic              e_req;
    logic              e_we;
    logic [3:0]        e_be;
    logic [ADDR_W-1:0] e_addr;
    logic [31:0]       e_wdata;
    logic              e_ack;
    logic              e_rvalid;
    logic [31:0]       e_rdata;

    logic              mem_we;
    logic [3:0]        mem_be;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_rdata;

    // Arbiter view.
    modport slave (
        input  c_req, c_we, c_be, c_addr, c_wdata,
        input  e_req, e_we, e_be, e_addr, e_wdata,
        input  mem_rdata,
        output c_rdata, c_stall, e_ack, e_rvalid, e_rdata,
        output mem_we, mem_be, mem_addr, mem_wdata
    );

    // Environment view: pipeline, loader and memory together.
    modport master (
        output c_req, c_we, c_be, c_addr, c_wdata,
        output e_req, e_we, e_be, e_addr, e_wdata,
        output mem_rdata,
        input  c_rdata, c_stall, e_ack, e_rvalid, e_rdata,
        input  mem_we, mem_be, mem_addr, mem_wdata
    );

endinterface

// File: rtl/dm_arb_age.sv
// dm_arb_age: ages a pending external request and raises forceGrant once it has waited MAX_WAIT cycles.
module dm_arb_age #(
    parameter int MAX_WAIT = 4
) (
    input  logic clk,
    input  logic reset_n,
    input  logic req,
    input  logic ack,
    output logic forceGrant
);
    localparam int            CW      = $clog2(MAX_WAIT + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(MAX_WAIT);

    logic [CW-1:0] waitCnt;

    // Count denied cycles of a held request; an ack or a dropped request restarts the count.
    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) waitCnt <= '0;
        else waitCnt <= (!req || ack) ? '0 : (waitCnt == CNT_MAX) ? waitCnt : waitCnt + 1'b1;

    assign forceGrant = waitCnt == CNT_MAX;

endmodule

// File: rtl/dm_arbiter.sv
// dm_arbiter: fixed-priority CPU / aged external arbiter for the shared data memory.
// Define DM_ARBITER_LOG_EN to trace every memory write in simulation.
module dm_arbiter
    import dm_arb_pkg::*;
#(
    parameter int MAX_WAIT = 4,
    parameter int ADDR_W   = DM_ADDR_W
) (
    input logic         clk,
    input logic         reset_n,
    dm_arbiter_if.slave bus
);
    portSel_t          sel;
    logic              forceGrant;
    logic              grantC;
    logic              grantE;
    logic              eRead;
    logic              memWe;
    logic [3:0]        memBe;
    logic [ADDR_W-1:0] memAddr;
    logic [31:0]       memWdata;
    logic              eRvalid;
    logic [31:0]       eRdata;

    dm_arb_age #(.MAX_WAIT(MAX_WAIT)) uAge (
        .clk,
        .reset_n,
        .req(bus.e_req),
        .ack(grantE),
        .forceGrant
    );

    // Pick the winner: an aged E request beats the CPU, otherwise the CPU has priority; nothing wins in reset.
    always_comb begin
        sel = PORT_NONE;
        if (reset_n)
            sel = (bus.e_req && (forceGrant || !bus.c_req)) ? PORT_E : bus.c_req ? PORT_C : PORT_NONE;
    end

    assign grantC = sel == PORT_C;
    assign grantE = sel == PORT_E;
    assign eRead  = grantE && !bus.e_we;

    // Steer the winner onto the memory port; an idle port carries CPU address/data with strobes off.
    always_comb begin
        memWe    = grantE ? bus.e_we : grantC && bus.c_we;
        memBe    = grantE ? bus.e_be : grantC ? bus.c_be : BE_NONE;
        memAddr  = grantE ? bus.e_addr : bus.c_addr;
        memWdata = grantE ? bus.e_wdata : bus.c_wdata;
    end

    // Capture external read data one cycle after its grant; data holds between reads.
    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) begin
            eRvalid <= 1'b0;
            eRdata  <= '0;
        end else begin
            eRvalid <= eRead;
            if (eRead) eRdata <= bus.mem_rdata;
        end

    assign bus.c_rdata   = bus.mem_rdata;
    assign bus.c_stall   = bus.c_req && !grantC && reset_n;
    assign bus.e_ack     = grantE;
    assign bus.e_rvalid  = eRvalid;
    assign bus.e_rdata   = eRdata;
    assign bus.mem_we    = memWe;
    assign bus.mem_be    = memBe;
    assign bus.mem_addr  = memAddr;
    assign bus.mem_wdata = memWdata;

`ifdef DM_ARBITER_LOG_EN
    // Trace each committed write with the winning port and the lane-masked data.
    always_ff @(posedge clk)
        if (reset_n && memWe)
            $display("%s*%h <= %h", grantE ? "E " : "C ", {20'b0, memAddr, 2'b00}, memWdata & beMask(memBe));
`endif

endmodule

// File: tb/tb_dm_arbiter.sv
// tb_dm_arbiter: directed and randomized bench for dm_arbiter against a behavioural arbitration/memory model.
module tb_dm_arbiter;
    import dm_arb_pkg::*;

    localparam int MAXW = 4;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    dm_arbiter_if #(.ADDR_W(10)) bus ();

    dm_arbiter #(.MAX_WAIT(MAXW), .ADDR_W(10)) dut (
        .clk(clk),
        .reset_n(reset_n),
        .bus(bus)
    );

    always #5 clk = ~clk;

    // Environment memory seen by the DUT.
    logic [31:0] ram [0:1023] = '{default: 32'h0};

    assign bus.mem_rdata = ram[bus.mem_addr];

    always @(posedge clk)
        if (bus.mem_we)
            for (int k = 0; k < 4; k++)
                if (bus.mem_be[k]) ram[bus.mem_addr][8*k +: 8] <= bus.mem_wdata[8*k +: 8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d, input logic [3:0] be);
        logic [31:0] r;
        r = old;
        for (int k = 0; k < 4; k++) if (be[k]) r[8*k +: 8] = d[8*k +: 8];
        return r;
    endfunction

    // Reference model: memory contents, cycles E has been refused, pending read response.
    logic [31:0] refMem [0:1023] = '{default: 32'h0};
    int          denied = 0;
    bit          expRvalid = 1'b0;
    logic [31:0] expRdata = 32'h0;
    bit          ackSeen = 1'b0;

    always @(negedge clk) begin
        bit gE;
        bit gC;
        ackSeen = bus.e_ack;
        if (!reset_n) begin
            chk("rst c_stall", bus.c_stall, 0);
            chk("rst e_ack", bus.e_ack, 0);
            chk("rst mem_we", bus.mem_we, 0);
            chk("rst mem_be", bus.mem_be, 0);
            chk("rst e_rvalid", bus.e_rvalid, 0);
            chk("rst e_rdata", bus.e_rdata, 0);
            denied = 0;
            expRvalid = 1'b0;
            expRdata = 32'h0;
        end else begin
            gE = bus.e_req && (denied >= MAXW || !bus.c_req);
            gC = bus.c_req && !gE;
            chk("mdl c_stall", bus.c_stall, bus.c_req && !gC);
            chk("mdl e_ack", bus.e_ack, gE);
            chk("mdl mem_we", bus.mem_we, gE ? bus.e_we : gC && bus.c_we);
            chk("mdl mem_be", bus.mem_be, gE ? bus.e_be : gC ? bus.c_be : BE_NONE);
            chk("mdl mem_addr", bus.mem_addr, gE ? bus.e_addr : bus.c_addr);
            chk("mdl mem_wdata", bus.mem_wdata, gE ? bus.e_wdata : bus.c_wdata);
            chk("mdl e_rvalid", bus.e_rvalid, expRvalid);
            chk("mdl e_rdata", bus.e_rdata, expRdata);
            if (gC && !bus.c_we) chk("mdl c_rdata", bus.c_rdata, refMem[bus.c_addr]);
            expRvalid = gE && !bus.e_we;
            if (expRvalid) expRdata = refMem[bus.e_addr];
            if (gC && bus.c_we) refMem[bus.c_addr] = merge(refMem[bus.c_addr], bus.c_wdata, bus.c_be);
            if (gE && bus.e_we) refMem[bus.e_addr] = merge(refMem[bus.e_addr], bus.e_wdata, bus.e_be);
            denied = (bus.e_req && !gE) ? ((denied < MAXW) ? denied + 1 : MAXW) : 0;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.c_req = 0; bus.c_we = 0; bus.c_be = BE_NONE; bus.c_addr = '0; bus.c_wdata = '0;
        bus.e_req = 0; bus.e_we = 0; bus.e_be = BE_NONE; bus.e_addr = '0; bus.e_wdata = '0;
    endtask

    task automatic cpu(input bit we, input logic [9:0] a, input logic [31:0] d, input logic [3:0] be);
        bus.c_req = 1; bus.c_we = we; bus.c_addr = a; bus.c_wdata = d; bus.c_be = be;
    endtask

    task automatic ext(input bit we, input logic [9:0] a, input logic [31:0] d, input logic [3:0] be);
        bus.e_req = 1; bus.e_we = we; bus.e_addr = a; bus.e_wdata = d; bus.e_be = be;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        idle();
        cpu(1, 10'h001, 32'h12345678, BE_WORD);
        ext(1, 10'h002, 32'h87654321, BE_WORD);
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset c_stall", bus.c_stall, 0);
        chk("reset e_ack", bus.e_ack, 0);
        chk("reset e_rvalid", bus.e_rvalid, 0);
        chk("reset e_rdata", bus.e_rdata, 0);
        chk("reset wait_cnt", 32'(dut.uAge.waitCnt), 0);
        step();
        reset_n = 1;
        idle();
        cpu(1, 10'h010, 32'hDEADBEEF, BE_WORD);
        @(negedge clk);
        chk("preload c_stall", bus.c_stall, 0);
        chk("preload mem_we", bus.mem_we, 1);
        step();
        idle();
        ext(0, 10'h010, 32'h0, BE_WORD);
        @(negedge clk);
        chk("eread ack cycle0", bus.e_ack, 1);
        step();
        idle();
        @(negedge clk);
        chk("eread rvalid cycle1", bus.e_rvalid, 1);
        chk("eread rdata cycle1", bus.e_rdata, 32'hDEADBEEF);
        step();
        cpu(0, 10'h010, 32'h0, BE_WORD);
        ext(0, 10'h010, 32'h0, BE_WORD);
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            chk($sformatf("force stall c%0d", k), bus.c_stall, 0);
            chk($sformatf("force ack c%0d", k), bus.e_ack, 0);
            chk($sformatf("force c_rdata c%0d", k), bus.c_rdata, 32'hDEADBEEF);
            step();
        end
        @(negedge clk);
        chk("force stall c5", bus.c_stall, 1);
        chk("force ack c5", bus.e_ack, 1);
        step();
        @(negedge clk);
        chk("force stall c6", bus.c_stall, 0);
        chk("force ack c6", bus.e_ack, 0);
        chk("force rvalid c6", bus.e_rvalid, 1);
        step();
        idle();
        cpu(1, 10'h020, 32'h11111111, BE_WORD);
        ext(1, 10'h020, 32'h22222222, BE_WORD);
        @(negedge clk);
        chk("collide e_ack", bus.e_ack, 0);
        chk("collide wdata", bus.mem_wdata, 32'h11111111);
        step();
        bus.c_req = 0;
        @(negedge clk);
        chk("collide mem after C", ram[10'h020], 32'h11111111);
        chk("collide late ack", bus.e_ack, 1);
        step();
        idle();
        @(negedge clk);
        chk("collide mem after E", ram[10'h020], 32'h22222222);
        chk("collide no rvalid", bus.e_rvalid, 0);
        step();
        cpu(1, 10'h030, 32'hFFFFFFFF, BE_WORD);
        step();
        idle();
        ext(1, 10'h030, 32'hAABBCCDD, 4'b0011);
        @(negedge clk);
        chk("partial ack", bus.e_ack, 1);
        step();
        idle();
        @(negedge clk);
        chk("partial mem", ram[10'h030], 32'hFFFFCCDD);
        chk("partial rvalid", bus.e_rvalid, 0);
        step();
        ext(1, 10'h030, 32'h12345678, BE_NONE);
        @(negedge clk);
        chk("zero-be ack", bus.e_ack, 1);
        chk("zero-be mem_we", bus.mem_we, 1);
        chk("zero-be mem_be", bus.mem_be, 0);
        step();
        idle();
        @(negedge clk);
        chk("zero-be mem", ram[10'h030], 32'hFFFFCCDD);
        step();
        cpu(0, 10'h030, 32'h0, BE_WORD);
        ext(1, 10'h040, 32'h55555555, BE_WORD);
        repeat (4) step();
        chk("rstforce ack before", bus.e_ack, 1);
        chk("rstforce we before", bus.mem_we, 1);
        #1;
        reset_n = 0;
        #1;
        chk("rstforce ack", bus.e_ack, 0);
        chk("rstforce mem_we", bus.mem_we, 0);
        chk("rstforce wait_cnt", 32'(dut.uAge.waitCnt), 0);
        chk("rstforce c_stall", bus.c_stall, 0);
        bus.e_req = 0;
        step();
        step();
        reset_n = 1;
        @(negedge clk);
        chk("post-rst c_stall", bus.c_stall, 0);
        chk("post-rst e_ack", bus.e_ack, 0);
        chk("post-rst c_rdata", bus.c_rdata, 32'hFFFFCCDD);
        chk("post-rst no commit", ram[10'h040], 0);
        for (int i = 0; i < 2000; i++) begin
            step();
            reset_n = $urandom_range(0, 299) != 0;
            bus.c_req = (i < 1000) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 1) != 0);
            bus.c_we = 1'($urandom_range(0, 1));
            bus.c_be = 4'($urandom);
            bus.c_addr = 10'($urandom_range(0, 15));
            bus.c_wdata = $urandom;
            if (!bus.e_req || ackSeen) begin
                bus.e_req = $urandom_range(0, 2) != 0;
                bus.e_we = 1'($urandom_range(0, 1));
                bus.e_be = 4'($urandom);
                bus.e_addr = 10'($urandom_range(0, 15));
                bus.e_wdata = $urandom;
            end
        end
        step();
        reset_n = 1;
        idle();
        repeat (2) step();
        for (int a = 0; a < 16; a++) chk($sformatf("final mem %0d", a), ram[a], refMem[a]);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
